uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with an internal transmit FIFO, optional parity, 1 or 2 stop bits and back-to-back framing. The host pushes words through a valid/ready handshake. The block serialises them LSB-first on o_uart_tx at a fixed baud rate, with no idle gap while the FIFO holds data. It sits between the CPU-side peripheral bus logic and the board TX pin.

Parameters:
CLK_FRE, 100, system clock frequency in MHz
BAUD_RATE, 9600, line rate in bit/s; CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit (integer, >= 4)
DATA_WIDTH, 8, data bits per frame, legal range 5..9
PARITY_ON, 0, 1 = append a parity bit, 0 = no parity bit
PARITY_TYPE, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_ON = 0)
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of two, >= 2

Ports:
i_clk_sys  in  1  system clock; all logic on the rising edge
i_rst_n  in  1  reset, asynchronous assert, active-low
i_data_tx  in  DATA_WIDTH  word to transmit
i_data_valid  in  1  i_data_tx valid; a push occurs on an edge where i_data_valid && o_data_ready
o_data_ready  out  1  FIFO not full
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently stored
o_uart_tx  out  1  serial line, idle high
o_busy  out  1  high while a frame is on the line (START..STOP)
out_done  out  1  one-cycle pulse at the end of each frame's last stop bit

Behaviour:
- Reset (async, i_rst_n low): o_uart_tx=1, o_busy=0, out_done=0, o_fifo_count=0, o_data_ready=1, FIFO pointers=0, FSM=IDLE, baud counter=0. Reset asserted mid-frame aborts the frame: the line returns high immediately and all queued words are discarded.
- FIFO:
  - Synchronous, first-word-fall-through from the FSM's point of view.
  - A push when full cannot occur, because o_data_ready is low when full.
  - A pop only occurs when the FIFO is non-empty.
  - Simultaneous push and pop leaves the count unchanged. This includes count = FIFO_DEPTH-1 with a pop, and count = 1 with a push.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud counter: counts 0..CYCLE-1 while o_busy and restarts at 0 on every bit boundary. Every bit, including each stop bit, is held for exactly CYCLE clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line high. If o_fifo_count != 0, pop the head word into the shift register, clear the parity accumulator, drive o_uart_tx=0, set o_busy=1 and go to START. All of this happens on the same edge.
  - START: after CYCLE clocks, drive the shift register LSB and go to DATA.
  - DATA: each bit lasts CYCLE clocks; shift right and XOR each sent bit into the parity accumulator. After DATA_WIDTH bits, go to PARITY if PARITY_ON, else go to STOP.
  - PARITY: drive accumulator XOR PARITY_TYPE, so the count of ones over data plus parity is even for TYPE 0 and odd for TYPE 1. Hold for CYCLE clocks, then go to STOP.
  - STOP: line high for STOP_BITS*CYCLE clocks. On the final clock, pulse out_done. Then, on the same edge:
    - if the FIFO is non-empty, pop, drive 0 and enter START (no idle bit between frames);
    - otherwise enter IDLE and clear o_busy.
- Latency: a word accepted on edge n into an empty FIFO with the FSM idle produces the start-bit falling edge on edge n+1.
- Frame length: (1 + DATA_WIDTH + PARITY_ON + STOP_BITS)*CYCLE clocks.
- Pushes during transmission are always allowed while not full and never disturb the frame in progress.

Test Plan:
1. CLK_FRE=1, BAUD_RATE=100000 (CYCLE=10), 8N1; push 0xA5 once -> line shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 10 clocks; out_done pulses exactly once, 100 clocks after the start-bit edge; o_busy then falls.
2. PARITY_ON=1: push 0x07 with PARITY_TYPE=0 -> parity bit 1; with PARITY_TYPE=1 -> parity bit 0; frame length 110 clocks.
3. FIFO_DEPTH=4; hold i_data_valid high with data 0x01..0x06 from idle -> o_fifo_count reaches 4 and o_data_ready drops; 0x06 is accepted only after the next pop; all six words appear on the line in order.
4. Two words queued (0x55, 0xAA) -> second start bit begins on the edge immediately after the first frame's last stop clock; out_done pulses 100 clocks apart; o_busy stays high throughout.
5. STOP_BITS=2, push 0xFF -> line high for 20 clocks after the last data bit; frame length 110 clocks.
6. Three words queued; assert i_rst_n low mid-DATA -> o_uart_tx=1, o_fifo_count=0 and o_busy=0 immediately; after release, no further frames appear until the next push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal first-word-fall-through TX FIFO.
// Configurable word width, parity and stop bits; queued frames go out back to back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FRE     = 100,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk_sys,
  input  logic                          i_rst_n,
  input  logic [DATA_WIDTH-1:0]         i_data_tx,
  input  logic                          i_data_valid,
  output logic                          o_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic                          out_done
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W = $clog2(CYCLE);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CYCLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_INV   = (PARITY_TYPE != 0);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and pointers; pointers wrap naturally since depth is a power of two.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  push, pop, fifo_empty;

  assign o_data_ready = (count != FULL_CNT);
  assign o_fifo_count = count;
  assign fifo_empty   = (count == '0);
  assign push         = i_data_valid && o_data_ready;

  always_ff @(posedge i_clk_sys) begin
    if (push) mem[wr_ptr] <= i_data_tx;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialiser state
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != IDLE);
  assign out_done  = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          par_d   = 1'b0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_ON != 0) begin
              tx_d    = par_q ^ shift_q[0] ^ PAR_INV;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem[rd_ptr];
              par_d   = 1'b0;
              tx_d    = 1'b0;
              state_d = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances at 10 clocks per bit (8N1, 8E1, 8O1, 8N2), depth 4.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid_a = 1'b0, valid_e = 1'b0, valid_o = 1'b0, valid_s = 1'b0;

  logic       ready_a, ready_e, ready_o, ready_s;
  logic [2:0] count_a, count_e, count_o, count_s;
  logic       tx_a, tx_e, tx_o, tx_s;
  logic       busy_a, busy_e, busy_o, busy_s;
  logic       done_a, done_e, done_o, done_s;

  int checks = 0;
  int failures = 0;

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_ON(0),
                 .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid_a),
    .o_data_ready(ready_a), .o_fifo_count(count_a), .o_uart_tx(tx_a),
    .o_busy(busy_a), .out_done(done_a));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_ON(1),
                 .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid_e),
    .o_data_ready(ready_e), .o_fifo_count(count_e), .o_uart_tx(tx_e),
    .o_busy(busy_e), .out_done(done_e));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_ON(1),
                 .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_o (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid_o),
    .o_data_ready(ready_o), .o_fifo_count(count_o), .o_uart_tx(tx_o),
    .o_busy(busy_o), .out_done(done_o));

  uart_tx_fifo #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_WIDTH(8), .PARITY_ON(0),
                 .PARITY_TYPE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
    .i_clk_sys(clk), .i_rst_n(rst_n), .i_data_tx(data), .i_data_valid(valid_s),
    .o_data_ready(ready_s), .o_fifo_count(count_s), .o_uart_tx(tx_s),
    .o_busy(busy_s), .out_done(done_s));

  // Observation mux: which instance capture() records.
  int   sel = 0;
  logic sel_tx, sel_busy, sel_done;
  always_comb begin
    sel_tx = tx_a; sel_busy = busy_a; sel_done = done_a;
    case (sel)
      1: begin sel_tx = tx_e; sel_busy = busy_e; sel_done = done_e; end
      2: begin sel_tx = tx_o; sel_busy = busy_o; sel_done = done_o; end
      3: begin sel_tx = tx_s; sel_busy = busy_s; sel_done = done_s; end
      default: ;
    endcase
  end

  logic cap_tx[400];
  logic cap_busy[400];
  logic cap_done[400];

  // Sample i is the cycle following the (i)th edge after the call.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i] = sel_tx; cap_busy[i] = sel_busy; cap_done[i] = sel_done;
    end
  endtask

  task automatic set_valid(input int which, input logic v);
    case (which)
      1: valid_e = v;
      2: valid_o = v;
      3: valid_s = v;
      default: valid_a = v;
    endcase
  endtask

  // Returns #1 after the accepting edge.
  task automatic push_one(input int which, input logic [7:0] d);
    @(posedge clk); #1;
    data = d; set_valid(which, 1'b1);
    @(posedge clk); #1;
    set_valid(which, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (count_a !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got tx=%b busy=%b exp tx=1 busy=0", tx_a, busy_a);
    end
  endtask

  task automatic test_frame_8n1;
    logic [9:0] fb;
    int nd, first_d;
    logic bad;
    fb = 10'b1101001010;  // stop, 0xA5 MSB..LSB, start
    sel = 0;
    push_one(0, 8'hA5);
    capture(110);
    checks++; if (cap_tx[0] !== 1'b1) begin failures++; $display("FAIL n1_pre_start got=%b exp=1", cap_tx[0]); end
    for (int j = 0; j < 10; j++) begin
      bad = 1'b0;
      for (int k = 1; k <= 10; k++) if (cap_tx[10*j + k] !== fb[j]) bad = 1'b1;
      checks++; if (bad) begin failures++; $display("FAIL n1_bit%0d not held at %b for 10 clocks", j, fb[j]); end
    end
    nd = 0; first_d = -1;
    for (int i = 0; i < 110; i++) if (cap_done[i] === 1'b1) begin nd++; if (first_d < 0) first_d = i; end
    checks++; if (nd !== 1) begin failures++; $display("FAIL n1_done_count got=%0d exp=1", nd); end
    checks++; if (first_d !== 100) begin failures++; $display("FAIL n1_done_pos got=%0d exp=100", first_d); end
    checks++; if (cap_busy[100] !== 1'b1 || cap_busy[101] !== 1'b0) begin
      failures++; $display("FAIL n1_busy_fall got=%b%b exp=10", cap_busy[100], cap_busy[101]);
    end
  endtask

  task automatic test_parity;
    logic [10:0] fb;
    int nd, first_d;
    logic bad;
    for (int p = 1; p <= 2; p++) begin
      fb = (p == 1) ? 11'b11000001110 : 11'b10000001110;  // 0x07 even -> parity 1, odd -> 0
      sel = p;
      push_one(p, 8'h07);
      capture(120);
      for (int j = 0; j < 11; j++) begin
        bad = 1'b0;
        for (int k = 1; k <= 10; k++) if (cap_tx[10*j + k] !== fb[j]) bad = 1'b1;
        checks++; if (bad) begin failures++; $display("FAIL par%0d_bit%0d exp=%b", p, j, fb[j]); end
      end
      nd = 0; first_d = -1;
      for (int i = 0; i < 120; i++) if (cap_done[i] === 1'b1) begin nd++; if (first_d < 0) first_d = i; end
      checks++; if (nd !== 1 || first_d !== 110) begin
        failures++; $display("FAIL par%0d_done got count=%0d pos=%0d exp count=1 pos=110", p, nd, first_d);
      end
      checks++; if (cap_busy[111] !== 1'b0) begin failures++; $display("FAIL par%0d_busy_after got=%b exp=0", p, cap_busy[111]); end
    end
  endtask

  task automatic test_two_stop;
    logic bad;
    int nd, first_d;
    sel = 3;
    push_one(3, 8'hFF);
    capture(120);
    checks++; if (cap_tx[5] !== 1'b0) begin failures++; $display("FAIL s2_start got=%b exp=0", cap_tx[5]); end
    bad = 1'b0;
    for (int i = 11; i <= 110; i++) if (cap_tx[i] !== 1'b1) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL s2_line_high data+stop not all 1"); end
    nd = 0; first_d = -1;
    for (int i = 0; i < 120; i++) if (cap_done[i] === 1'b1) begin nd++; if (first_d < 0) first_d = i; end
    checks++; if (nd !== 1 || first_d !== 110) begin
      failures++; $display("FAIL s2_done got count=%0d pos=%0d exp count=1 pos=110", nd, first_d);
    end
    checks++; if (cap_busy[110] !== 1'b1 || cap_busy[111] !== 1'b0) begin
      failures++; $display("FAIL s2_busy got=%b%b exp=10", cap_busy[110], cap_busy[111]);
    end
  endtask

  task automatic test_fifo_fill;
    logic hist[700];
    int max_cnt, accept6, ready50;
    logic full_bad, acc;
    logic [7:0] w;
    max_cnt = 0; accept6 = -1; ready50 = -1; full_bad = 1'b0;
    sel = 0;
    @(posedge clk); #1;
    data = 8'h01; valid_a = 1'b1;
    for (int c = 1; c <= 640; c++) begin
      @(negedge clk);
      hist[c] = tx_a;
      if (int'(count_a) > max_cnt) max_cnt = int'(count_a);
      if (count_a == 3'd4 && ready_a !== 1'b0) full_bad = 1'b1;
      if (c == 50) ready50 = int'(ready_a);
      acc = valid_a && ready_a;
      @(posedge clk); #1;
      if (acc) begin
        if (data == 8'h06) begin accept6 = c; valid_a = 1'b0; end
        else data = data + 8'h01;
      end
    end
    checks++; if (max_cnt !== 4) begin failures++; $display("FAIL ff_max_count got=%0d exp=4", max_cnt); end
    checks++; if (full_bad) begin failures++; $display("FAIL ff_ready_when_full got=1 exp=0"); end
    checks++; if (ready50 !== 0) begin failures++; $display("FAIL ff_ready_mid got=%0d exp=0", ready50); end
    checks++; if (accept6 !== 103) begin failures++; $display("FAIL ff_accept6 got=%0d exp=103", accept6); end
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < 8; j++) w[j] = hist[3 + 100*f + 10*(j + 1) + 5];
      checks++;
      if (hist[3 + 100*f + 5] !== 1'b0 || hist[3 + 100*f + 95] !== 1'b1 || w !== 8'(f + 1)) begin
        failures++;
        $display("FAIL ff_word%0d got=%h start=%b stop=%b exp=%h start=0 stop=1",
                 f, w, hist[3 + 100*f + 5], hist[3 + 100*f + 95], 8'(f + 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1, w2;
    int nd, d1, d2;
    logic bad;
    sel = 0;
    repeat (20) @(posedge clk);
    #1; data = 8'h55; valid_a = 1'b1;
    @(posedge clk); #1; data = 8'hAA;
    @(posedge clk); #1; valid_a = 1'b0;
    capture(210);
    for (int j = 0; j < 8; j++) begin
      w1[j] = cap_tx[10*(j + 1) + 5];
      w2[j] = cap_tx[100 + 10*(j + 1) + 5];
    end
    checks++; if (w1 !== 8'h55) begin failures++; $display("FAIL b2b_word1 got=%h exp=55", w1); end
    checks++; if (w2 !== 8'hAA) begin failures++; $display("FAIL b2b_word2 got=%h exp=aa", w2); end
    checks++; if (cap_tx[99] !== 1'b1 || cap_tx[100] !== 1'b0) begin
      failures++; $display("FAIL b2b_gap got=%b%b exp=10", cap_tx[99], cap_tx[100]);
    end
    nd = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 210; i++) if (cap_done[i] === 1'b1) begin
      nd++; if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
    end
    checks++; if (nd !== 2 || d1 !== 99 || d2 !== 199) begin
      failures++; $display("FAIL b2b_done got count=%0d pos=%0d,%0d exp count=2 pos=99,199", nd, d1, d2);
    end
    bad = 1'b0;
    for (int i = 0; i < 200; i++) if (cap_busy[i] !== 1'b1) bad = 1'b1;
    checks++; if (bad || cap_busy[200] !== 1'b0) begin
      failures++; $display("FAIL b2b_busy got gap=%b end=%b exp gap=0 end=0", bad, cap_busy[200]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic bad;
    sel = 0;
    repeat (20) @(posedge clk);
    #1; data = 8'h11; valid_a = 1'b1;
    @(posedge clk); #1; data = 8'h22;
    @(posedge clk); #1; data = 8'h33;
    @(posedge clk); #1; valid_a = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (count_a !== 3'd2 || busy_a !== 1'b1) begin
      failures++; $display("FAIL rst_pre got count=%0d busy=%b exp count=2 busy=1", count_a, busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL rst_mid_tx got=%b exp=1", tx_a); end
    checks++; if (count_a !== 3'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", count_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    capture(300);
    bad = 1'b0;
    for (int i = 0; i < 300; i++) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0 || cap_done[i] !== 1'b0) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL rst_quiet got activity after release exp idle"); end
    push_one(0, 8'h3C);
    capture(2);
    checks++; if (cap_tx[0] !== 1'b1 || cap_tx[1] !== 1'b0) begin
      failures++; $display("FAIL rst_restart got=%b%b exp=10", cap_tx[0], cap_tx[1]);
    end
    repeat (110) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_two_stop();
    test_fifo_fill();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
